// File: rtl/parking_pkg.sv
// parking_pkg: shared sizes and FSM state encoding for the parking gate controller.
package parking_pkg;
    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = 3;
    localparam int CNT_W     = 4;
    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT_ENTRY,
        S_GRANT_EXIT,
        S_REJECT_EXIT,
        S_GATE_OPEN
    } state_t;
endpackage

// File: rtl/parking_capacity_counter.sv
// parking_capacity_counter: popcount of occupied slots and the remaining free count.
module parking_capacity_counter
    import parking_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] i_occ,
    output logic [CNT_W-1:0]     o_parked,
    output logic [CNT_W-1:0]     o_empty
);
    always_comb begin
        o_parked = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            o_parked = o_parked + CNT_W'(i_occ[i]);
        o_empty = CNT_W'(NUM_SLOTS) - o_parked;
    end
endmodule

// File: rtl/parking_gate_controller.sv
// parking_gate_controller: grants entry/exit moves, tracks slot occupancy, times the gate.
// Optional PARKING_STATS_EN adds a saturating total_entries counter output.
module parking_gate_controller
    import parking_pkg::*;
#(
    parameter int GATE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 entry_req,
    input  logic                 exit_req,
    input  logic [SLOT_W-1:0]    exit_slot,
    output logic                 entry_ack,
    output logic [SLOT_W-1:0]    entry_slot,
    output logic                 exit_ack,
    output logic                 exit_err,
    output logic                 gate_open,
    output logic [NUM_SLOTS-1:0] occupancy,
    output logic [CNT_W-1:0]     parked,
    output logic [CNT_W-1:0]     empty,
`ifdef PARKING_STATS_EN
    output logic [7:0]           total_entries,
`endif
    output logic                 full
);
    state_t                 r_state, w_next;
    logic [NUM_SLOTS-1:0]   r_occ;
    logic                   r_last_exit;
    logic [CNT_W-1:0]       r_cnt;
    logic [SLOT_W-1:0]      w_free_slot;
    logic                   w_entry_ok, w_exit_hit, w_exit_pick;

    // Lowest-index free slot wins.
    always_comb begin
        w_free_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (!r_occ[i]) w_free_slot = SLOT_W'(i);
    end

    assign w_entry_ok  = entry_req & ~full;
    assign w_exit_hit  = exit_req & r_occ[exit_slot];
    // Exit yields to a competing entry only when exit was the side served last.
    assign w_exit_pick = exit_req & (~w_entry_ok | ~r_last_exit);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:        w_next = w_exit_pick ? (w_exit_hit ? S_GRANT_EXIT : S_REJECT_EXIT)
                                  : w_entry_ok ? S_GRANT_ENTRY : S_IDLE;
            S_GRANT_ENTRY: w_next = S_GATE_OPEN;
            S_GRANT_EXIT:  w_next = S_GATE_OPEN;
            S_REJECT_EXIT: w_next = S_IDLE;
            S_GATE_OPEN:   w_next = (r_cnt == CNT_W'(GATE_CYCLES - 1)) ? S_IDLE : S_GATE_OPEN;
            default:       w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_occ       <= '0;
            r_last_exit <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == S_GATE_OPEN) ? r_cnt + 1'b1 : '0;
            if (r_state == S_GRANT_ENTRY) begin
                r_occ[w_free_slot] <= 1'b1;
                r_last_exit        <= 1'b0;
            end
            if (r_state == S_GRANT_EXIT) begin
                r_occ[exit_slot] <= 1'b0;
                r_last_exit      <= 1'b1;
            end
        end
    end

`ifdef PARKING_STATS_EN
    logic [7:0] r_total;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_total <= '0;
        else if (r_state == S_GRANT_ENTRY && r_total != 8'hFF)
            r_total <= r_total + 8'd1;
    end
    assign total_entries = r_total;
`endif

    parking_capacity_counter u_cap (
        .i_occ    (r_occ),
        .o_parked (parked),
        .o_empty  (empty)
    );

    assign entry_ack  = (r_state == S_GRANT_ENTRY);
    assign entry_slot = w_free_slot;
    assign exit_ack   = (r_state == S_GRANT_EXIT);
    assign exit_err   = (r_state == S_REJECT_EXIT);
    assign gate_open  = (r_state == S_GATE_OPEN);
    assign occupancy  = r_occ;
    assign full       = (parked == CNT_W'(NUM_SLOTS));
endmodule

// File: tb/tb_parking_gate_controller.sv
// tb_parking_gate_controller: directed self-checking bench for parking_gate_controller.
module tb_parking_gate_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic [2:0] exit_slot = 3'd0;
    logic       entry_ack, exit_ack, exit_err, gate_open, full;
    logic [2:0] entry_slot;
    logic [7:0] occupancy;
    logic [3:0] parked, empty;
`ifdef PARKING_STATS_EN
    logic [7:0] total_entries;
`endif
    int n_chk = 0;
    int n_err = 0;
    int lat, n;

    always #5 clk = ~clk;

    parking_gate_controller #(.GATE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .entry_req(entry_req), .exit_req(exit_req),
        .exit_slot(exit_slot), .entry_ack(entry_ack), .entry_slot(entry_slot),
        .exit_ack(exit_ack), .exit_err(exit_err), .gate_open(gate_open),
        .occupancy(occupancy), .parked(parked), .empty(empty),
`ifdef PARKING_STATS_EN
        .total_entries(total_entries),
`endif
        .full(full)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_resp(output int l);
        l = 0;
        while (!(entry_ack || exit_ack || exit_err) && l < 30) begin
            step();
            l++;
        end
    endtask

    task automatic gate_len(output int c);
        c = 0;
        step();
        while (gate_open && c < 20) begin
            c++;
            step();
        end
    endtask

    task automatic do_entry(input string tag, input logic [2:0] slot);
        entry_req = 1'b1;
        wait_resp(lat);
        chk({tag, "_lat"}, lat, 1);
        chk({tag, "_ack"}, entry_ack, 1);
        chk({tag, "_slot"}, entry_slot, slot);
        entry_req = 1'b0;
        gate_len(n);
        chk({tag, "_gate"}, n, 4);
    endtask

    initial begin
        #1;
        chk("rst_occ", occupancy, 8'h00);
        chk("rst_parked", parked, 0);
        chk("rst_empty", empty, 8);
        chk("rst_full", full, 0);
        chk("rst_gate", gate_open, 0);
        step();
        step();
        rst = 1'b0;
        step();

        do_entry("first", 3'd0);
        chk("first_occ", occupancy, 8'h01);
        chk("first_parked", parked, 1);
        chk("first_empty", empty, 7);

        for (int i = 1; i < 8; i++) do_entry("fill", 3'(i));
        chk("fill_occ", occupancy, 8'hFF);
        chk("fill_full", full, 1);
        chk("fill_parked", parked, 8);
        chk("fill_empty", empty, 0);

        entry_req = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (entry_ack) n++;
        end
        chk("full_noack", n, 0);

        exit_req = 1'b1;
        exit_slot = 3'd3;
        wait_resp(lat);
        chk("ex3_lat", lat, 1);
        chk("ex3_ack", exit_ack, 1);
        chk("ex3_noentry", entry_ack, 0);
        exit_req = 1'b0;
        gate_len(n);
        chk("ex3_gate", n, 4);
        chk("ex3_occ", occupancy, 8'hF7);
        chk("ex3_full", full, 0);
        wait_resp(lat);
        chk("refill_ack", entry_ack, 1);
        chk("refill_slot", entry_slot, 3);
        entry_req = 1'b0;
        gate_len(n);
        chk("refill_occ", occupancy, 8'hFF);

        rst = 1'b1;
        #1;
        chk("rst2_occ", occupancy, 8'h00);
        step();
        rst = 1'b0;
        step();
        do_entry("rr_pre0", 3'd0);
        do_entry("rr_pre1", 3'd1);
        entry_req = 1'b1;
        exit_req = 1'b1;
        exit_slot = 3'd0;
        wait_resp(lat);
        chk("rr1_exit", exit_ack, 1);
        chk("rr1_entry", entry_ack, 0);
        exit_req = 1'b0;
        gate_len(n);
        exit_req = 1'b1;
        exit_slot = 3'd1;
        wait_resp(lat);
        chk("rr2_entry", entry_ack, 1);
        chk("rr2_exit", exit_ack, 0);
        chk("rr2_slot", entry_slot, 0);
        entry_req = 1'b0;
        gate_len(n);
        wait_resp(lat);
        chk("rr3_exit", exit_ack, 1);
        exit_req = 1'b0;
        gate_len(n);
        chk("rr_occ", occupancy, 8'h01);

        exit_req = 1'b1;
        exit_slot = 3'd5;
        wait_resp(lat);
        chk("err_lat", lat, 1);
        chk("err_pulse", exit_err, 1);
        chk("err_noack", exit_ack, 0);
        exit_req = 1'b0;
        step();
        chk("err_gate", gate_open, 0);
        chk("err_once", exit_err, 0);
        chk("err_occ", occupancy, 8'h01);

        entry_req = 1'b1;
        wait_resp(lat);
        chk("abort_slot", entry_slot, 1);
        entry_req = 1'b0;
        step();
        chk("abort_gate_pre", gate_open, 1);
        chk("abort_occ_pre", occupancy, 8'h03);
        #2 rst = 1'b1;
        #1;
        chk("abort_gate", gate_open, 0);
        chk("abort_occ", occupancy, 8'h00);
        chk("abort_parked", parked, 0);
        chk("abort_empty", empty, 8);
        step();
        rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/parking_gate_controller.md
PARKING_GATE_CONTROLLER -- requirements
Module: parking_gate_controller

Interface
REQ-001 Parameter: GATE_CYCLES, 4, number of cycles the gate stays open per granted movement (legal 1..15).
REQ-002 Ports: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Ports: rst  input  1  asynchronous, active-high reset.
REQ-004 Ports: entry_req  input  1  car waiting at entry gate; held high until entry_ack.
REQ-005 Ports: exit_req  input  1  car leaving; held high until exit_ack or exit_err.
REQ-006 Ports: exit_slot  input  3  slot index vacated; stable while exit_req high.
REQ-007 Ports: entry_ack  output  1  one-cycle pulse, entry granted.
REQ-008 Ports: entry_slot  output  3  slot allocated to the granted car; valid while entry_ack high.
REQ-009 Ports: exit_ack  output  1  one-cycle pulse, exit granted.
REQ-010 Ports: exit_err  output  1  one-cycle pulse, exit_slot was already free.
REQ-011 Ports: gate_open  output  1  high while the gate is open.
REQ-012 Ports: occupancy  output  8  bit i = 1 means slot i occupied.
REQ-013 Ports: parked  output  4  popcount of occupancy (0..8).
REQ-014 Ports: empty  output  4  8 - parked.
REQ-015 Ports: full  output  1  high when parked == 8.

Function
REQ-016 FSM states IDLE, GRANT_ENTRY, GRANT_EXIT, REJECT_EXIT, GATE_OPEN; requests sampled only in IDLE.
REQ-017 IDLE: entry_req and not full -> GRANT_ENTRY; valid exit_req -> GRANT_EXIT; exit_req on a free slot -> REJECT_EXIT; otherwise stay.
REQ-018 Both eligible in IDLE: round-robin via last_served flag; serve the side not served last; after reset, exit wins first.
REQ-019 GRANT_ENTRY (1 cycle): entry_ack=1, entry_slot = lowest-index free slot, that bit set in occupancy at the end of the cycle -> GATE_OPEN.
REQ-020 GRANT_EXIT (1 cycle): exit_ack=1, occupancy[exit_slot] cleared at the end of the cycle -> GATE_OPEN.
REQ-021 REJECT_EXIT (1 cycle): exit_err=1, occupancy unchanged, gate stays closed -> IDLE; last_served unchanged.
REQ-022 GATE_OPEN: gate_open=1 for exactly GATE_CYCLES cycles, then -> IDLE; new requests ignored meanwhile.
REQ-023 Latency: request seen in IDLE at edge n -> ack high in cycle n+1 -> gate_open cycles n+2..n+1+GATE_CYCLES.
REQ-024 parked/empty/full combinational from the occupancy register; reflect an update in the cycle after the ack.
REQ-025 entry_req while full: no ack, entry waits in IDLE; pending exit_req still served.
REQ-026 Occupancy never exceeds 8 bits; no other write path exists.

Reset
REQ-027 rst high: state=IDLE, occupancy=8'h00, last_served=entry, gate counter=0, all pulses and gate_open=0; parked=0, empty=8, full=0.
REQ-028 Reset mid-GATE_OPEN or mid-grant aborts immediately; the granted movement is discarded with occupancy cleared.

Configuration
REQ-029 PARKING_STATS_EN defined: extra output total_entries (8 bits, reset 0) incremented on each entry_ack, saturating at 255.
REQ-030 PARKING_STATS_EN undefined: port and counter absent; all other behaviour identical.

Structure
REQ-031 Package parking_pkg holds NUM_SLOTS=8, SLOT_W=3, CNT_W=4 and the FSM state typedef.
REQ-032 parked/empty computed by one instance of parking_capacity_counter fed from the occupancy register; free-slot priority encoder stays inline.

Verification
REQ-033 Reset, then entry_req held -> entry_ack in 2nd cycle, entry_slot=0, occupancy=8'h01, gate_open 4 cycles, parked=1, empty=7.
REQ-034 Eight sequential entries -> slots 0..7, occupancy=8'hFF, full=1; 9th entry_req -> no ack for 20 cycles.
REQ-035 occupancy=8'hFF, exit_req slot 3 -> exit_ack, occupancy=8'hF7; next entry -> entry_slot=3.
REQ-036 entry_req and exit_req (slot 0) in same IDLE cycle after reset -> exit first, entry next; repeat pair -> entry first.
REQ-037 exit_req slot 5 with occupancy=8'h01 -> exit_err pulse, no gate_open, occupancy unchanged.
REQ-038 rst during GATE_OPEN -> gate_open=0 and occupancy=8'h00 immediately, without a clock edge.
